// File: rtl/acq_seq_ctrl.sv
// A-line acquisition sequencer: trigger-started ping-pong capture into two banks.
// Optional test pattern on wr_data when ACQ_TESTPAT_EN is defined.
module acq_seq_ctrl #(
  parameter int NSAMP = 2048,
  parameter int AW    = 12
) (
  input  logic          adclk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          trig,
  input  logic [11:0]   a2dc,
  input  logic [1:0]    bank_ack,
  input  logic          tp_en,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [11:0]   wr_data,
  output logic          wr_bank,
  output logic [1:0]    bank_rdy,
  output logic          busy,
  output logic [15:0]   ovr_cnt,
  output logic [15:0]   aline_cnt
);

  localparam logic [AW-1:0] LAST = AW'(NSAMP - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE
  } state_t;

  state_t state, next_state;

  logic          trig_q;
  logic          edge_det;
  logic [AW-1:0] cnt;
  logic [11:0]   din;
  logic          last_wr;
  logic          issue;
  logic          start;
  logic          drop;
  logic [1:0]    set_mask;

  assign edge_det = trig & ~trig_q;
  assign last_wr  = wr_en && (wr_addr == LAST);

`ifdef ACQ_TESTPAT_EN
  assign din = tp_en ? 12'(cnt) : a2dc;
`else
  logic unused_tp_en;
  assign unused_tp_en = tp_en;
  assign din = a2dc;
`endif

  always_ff @(posedge adclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // CAPTURE is held through the cycle that presents the last write,
  // so bank bookkeeping happens on the edge right after it.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (arm) next_state = WAIT_TRIG;
      WAIT_TRIG: begin
        unique case (1'b1)
          !arm:    next_state = IDLE;
          start:   next_state = CAPTURE;
          default: next_state = WAIT_TRIG;
        endcase
      end
      CAPTURE:   if (last_wr) next_state = arm ? WAIT_TRIG : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == CAPTURE);
    issue    = (state == CAPTURE) && !last_wr;
    start    = (state == WAIT_TRIG) && arm && edge_det
               && !bank_rdy[wr_bank];
    drop     = (state == WAIT_TRIG) && arm && edge_det
               && bank_rdy[wr_bank];
    set_mask = last_wr ? (2'b01 << wr_bank) : 2'b00;
  end

  always_ff @(posedge adclk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q    <= 1'b0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_bank   <= 1'b0;
      bank_rdy  <= 2'b00;
      ovr_cnt   <= '0;
      aline_cnt <= '0;
    end else begin
      trig_q <= trig;
      wr_en  <= issue;
      if (start) cnt <= '0;
      if (issue) begin
        wr_addr <= cnt;
        wr_data <= din;
        cnt     <= cnt + 1'b1;
      end
      // a set on the same edge as an ack of that bank wins
      bank_rdy <= (bank_rdy & ~bank_ack) | set_mask;
      if (last_wr) begin
        wr_bank   <= ~wr_bank;
        aline_cnt <= aline_cnt + 16'd1;
      end
      if (drop && (ovr_cnt != 16'hFFFF))
        ovr_cnt <= ovr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// Directed/randomized bench for acq_seq_ctrl with NSAMP=8, AW=3.
// Expected values come from a bank/counter model kept here.
module tb_acq_seq_ctrl;

  localparam int NS = 8;
  localparam int AW = 3;
`ifdef ACQ_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic          adclk;
  logic          rst_n;
  logic          arm;
  logic          trig;
  logic [11:0]   a2dc;
  logic [1:0]    bank_ack;
  logic          tp_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          wr_bank;
  logic [1:0]    bank_rdy;
  logic          busy;
  logic [15:0]   ovr_cnt;
  logic [15:0]   aline_cnt;

  int vectors;
  int miscompares;

  logic [1:0]  m_rdy;
  logic        m_bank;
  logic [15:0] m_ovr;
  logic [15:0] m_aline;

  acq_seq_ctrl #(.NSAMP(NS), .AW(AW)) dut (
    .adclk(adclk), .rst_n(rst_n), .arm(arm), .trig(trig),
    .a2dc(a2dc), .bank_ack(bank_ack), .tp_en(tp_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bank(wr_bank), .bank_rdy(bank_rdy), .busy(busy),
    .ovr_cnt(ovr_cnt), .aline_cnt(aline_cnt)
  );

  initial begin
    adclk = 1'b0;
    forever #5 adclk = ~adclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_rdy"}, 32'(bank_rdy), 32'(m_rdy));
    chk({tag, "_bank"}, 32'(wr_bank), 32'(m_bank));
    chk({tag, "_ovr"}, 32'(ovr_cnt), 32'(m_ovr));
    chk({tag, "_aline"}, 32'(aline_cnt), 32'(m_aline));
  endtask

  task automatic run_aline(input bit ramp, input bit fixed,
                           input bit mid_trig, input int drop_at,
                           input bit ack_last);
    logic [11:0] s [NS];
    logic [11:0] ed;
    logic        bank;
    bank = m_bank;
    for (int i = 0; i < NS; i++)
      s[i] = fixed ? 12'hABC : ramp ? 12'(100 + i) : 12'($urandom);
    trig = 1'b1;
    a2dc = fixed ? 12'hABC : 12'($urandom);
    @(negedge adclk);
    chk("lat_wr_en", 32'(wr_en), 0);
    chk("busy_start", 32'(busy), 1);
    trig = 1'b0;
    a2dc = s[0];
    for (int i = 0; i < NS; i++) begin
      @(negedge adclk);
      ed = (TP && tp_en) ? 12'(i) : s[i];
      chk("wr_en", 32'(wr_en), 1);
      chk("wr_addr", 32'(wr_addr), 32'(i));
      chk("wr_data", 32'(wr_data), 32'(ed));
      chk("wr_bank", 32'(wr_bank), 32'(bank));
      chk("busy", 32'(busy), 1);
      if (mid_trig && i == 3) trig = 1'b1;
      if (mid_trig && i == 4) trig = 1'b0;
      if (i == drop_at) arm = 1'b0;
      if (ack_last && i == NS - 1) bank_ack = 2'b01 << bank;
      a2dc = (i < NS - 1) ? s[i+1] : 12'($urandom);
    end
    @(negedge adclk);
    bank_ack = 2'b00;
    m_rdy[bank] = 1'b1;
    m_bank = ~bank;
    m_aline++;
    chk("end_wr_en", 32'(wr_en), 0);
    chk("end_busy", 32'(busy), 0);
    chk_status("end");
  endtask

  task automatic no_write(input bit counts);
    trig = 1'b1;
    @(negedge adclk);
    trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nw_wr_en", 32'(wr_en), 0);
      chk("nw_busy", 32'(busy), 0);
      @(negedge adclk);
    end
    if (counts) m_ovr++;
    chk_status("nw");
  endtask

  task automatic do_ack(input logic [1:0] mask);
    bank_ack = mask;
    @(negedge adclk);
    bank_ack = 2'b00;
    m_rdy = m_rdy & ~mask;
    chk("ack_rdy", 32'(bank_rdy), 32'(m_rdy));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk_status(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_rdy = 2'b00;
    m_bank = 1'b0;
    m_ovr = '0;
    m_aline = '0;
    rst_n = 1'b0;
    arm = 1'b0;
    trig = 1'b0;
    a2dc = 12'($urandom);
    bank_ack = 2'b00;
    tp_en = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge adclk);
    @(negedge adclk);
    rst_n = 1'b1;
    @(negedge adclk);

    no_write(1'b0);
    arm = 1'b1;
    @(negedge adclk);

    run_aline(1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_aline(1'b0, 1'b0, 1'b1, -1, 1'b0);
    no_write(1'b1);
    do_ack(2'b01);
    run_aline(1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("bank1_kept", 32'(bank_rdy[1]), 1);
    do_ack(2'b11);
    do_ack(2'b01);

    run_aline(1'b0, 1'b0, 1'b0, 2, 1'b0);
    no_write(1'b0);
    arm = 1'b1;
    @(negedge adclk);

    run_aline(1'b0, 1'b0, 1'b0, -1, 1'b1);
    chk("set_wins", 32'(bank_rdy), 32'h3);
    do_ack(2'b11);

    trig = 1'b1;
    @(negedge adclk);
    trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge adclk);
      chk("pre_rst_addr", 32'(wr_addr), 32'(i));
    end
    #2 rst_n = 1'b0;
    #1;
    m_rdy = 2'b00;
    m_bank = 1'b0;
    m_ovr = '0;
    m_aline = '0;
    chk_zero("midrst");
    @(negedge adclk);
    rst_n = 1'b1;
    @(negedge adclk);
    run_aline(1'b0, 1'b0, 1'b0, -1, 1'b0);

    tp_en = 1'b1;
    run_aline(1'b0, 1'b1, 1'b0, -1, 1'b0);
    tp_en = 1'b0;
    do_ack(2'b11);
    run_aline(1'b0, 1'b0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
